alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, multi-cycle integer execution unit for the RISC-V core: the RV32I/RV64I ALU operations plus the M-extension multiply/divide set, behind a valid/ready handshake. Single-cycle ops return after one registered cycle. MUL/DIV families run an iterative radix-2 datapath, one bit per cycle. It sits in the execute stage; the issue logic stalls on `in_ready` and writeback consumes results via `out_valid`/`out_ready`.

## Interface
- `XLEN`, 32: datapath width; power of two, 8..64.
- `TAG_W`, 5: width of the sideband tag (destination register index).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  abort the in-flight op and drop any pending result.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `in_op`  in  5  operation code (see Operation).
- `in_a`, `in_b`  in  XLEN  operands (rs1, rs2).
- `in_tag`  in  TAG_W  tag returned with the result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag of the op that produced `out_result`.

## Operation
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL, 0x06 SRL, 0x07 SRA, 0x08 SLT, 0x09 SLTU.
  - 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU.
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - Any other code is a single-cycle op with result 0.
- Arithmetic: two's complement, modulo 2^XLEN. Shift amount is `in_b[log2(XLEN)-1:0]`. SLT and SLTU return 0 or 1.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH, MULHSU and MULHU return the high XLEN bits with operand signedness s·s, s·u and u·u.
- Division rounds toward zero. The remainder takes the dividend's sign.
- Division by zero: DIV and DIVU return all ones. REM and REMU return the dividend.
- Signed overflow (DIV or REM with a = −2^(XLEN−1), b = −1): DIV returns a, REM returns 0.
- Both special cases finish in the single-cycle path.
- FSM:
  - IDLE: on accept, single-cycle ops go to DONE; iterative ops go to BUSY with the counter loaded with XLEN.
  - BUSY: the counter decrements each cycle; when it reaches 0, go to DONE.
  - DONE: hold `out_*` stable. On `out_ready`, go to IDLE, or start the newly accepted op in the same cycle.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is combinational and never depends on `in_valid`.
- Accept = `in_valid && in_ready && !flush`. Op, operands and tag are captured on accept. Inputs are don't-care otherwise.
- `flush`: on the next edge go to IDLE and clear `out_valid`. It has priority over a simultaneous accept and over a simultaneous `out_ready`.
- `rst`: same effect as `flush` and also zeroes all datapath registers. Reset mid-operation discards the op with no output.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_tag`=0, state IDLE, so `in_ready`=1 once `rst` is low.
- Latency is measured from the accept cycle to the first `out_valid` cycle:
  - Single-cycle ops and division special cases: 1.
  - MUL family and normal DIV/REM family: XLEN+1.
- Throughput: one single-cycle op per cycle when `out_ready` is held high (DONE→DONE back-to-back).
- While `out_valid`=1 and `out_ready`=0, `out_result` and `out_tag` do not change. No result is ever lost or duplicated.

## Configuration
- `ALU_MDU_DIV_EN` defined: divider datapath compiled in; behaviour as above.
- Undefined: no divider logic. Opcodes 0x14–0x17 behave as unknown opcodes: result 0, latency 1. The multiplier is unaffected.

## Test plan
- ADD 0x7FFFFFFF + 1 -> 0x80000000 one cycle after accept. SRA 0x80000000 by 31 -> 0xFFFFFFFF. SLTU 1 < 0xFFFFFFFF -> 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. `out_valid` exactly 33 cycles after accept. Tag 0x1F returned.
- DIV −7 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIV by 0 -> 0xFFFFFFFF in 1 cycle. DIV 0x80000000 / −1 -> 0x80000000; REM -> 0.
- Back-pressure: `out_ready` low for 5 cycles after a MUL completes -> result and tag stable, `in_ready`=0. On release, the next ADD is accepted in the same cycle.
- `flush` at cycle 10 of a DIVU -> `out_valid` never rises. `in_ready`=1 the next cycle. The following ADD returns correctly.
- With `ALU_MDU_DIV_EN` undefined: DIVU 100/3 -> 0 with latency 1. MUL 6×7 -> 42 with latency 33.

Source files
------------

// File: rtl/alu_mdu.sv
// Integer execution unit: single-cycle RV ALU ops plus an iterative radix-2 multiply/divide.
// Define ALU_MDU_DIV_EN to build the divider; without it, the divide opcodes return 0 after one cycle.
module alu_mdu #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN + 1);

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_AND    = 5'h02;
   localparam logic [4:0] OP_OR     = 5'h03;
   localparam logic [4:0] OP_XOR    = 5'h04;
   localparam logic [4:0] OP_SLL    = 5'h05;
   localparam logic [4:0] OP_SRL    = 5'h06;
   localparam logic [4:0] OP_SRA    = 5'h07;
   localparam logic [4:0] OP_SLT    = 5'h08;
   localparam logic [4:0] OP_SLTU   = 5'h09;
   localparam logic [4:0] OP_MULH   = 5'h11;
   localparam logic [4:0] OP_MULHSU = 5'h12;
   localparam logic [4:0] OP_DIV    = 5'h14;
   localparam logic [4:0] OP_DIVU   = 5'h15;
   localparam logic [4:0] OP_REM    = 5'h16;
   localparam logic [4:0] OP_REMU   = 5'h17;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [XLEN-1:0]    hi_reg, hi_next;
   logic [XLEN-1:0]    lo_reg, lo_next;
   logic [XLEN-1:0]    opnd_reg, opnd_next;
   logic               neg_reg, neg_next;
   logic               sel_hi_reg, sel_hi_next;
   logic [TAG_W-1:0]   tag_reg, tag_next;
   logic               out_valid_reg, out_valid_next;
   logic [XLEN-1:0]    out_result_reg, out_result_next;
   logic [TAG_W-1:0]   out_tag_reg, out_tag_next;
`ifdef ALU_MDU_DIV_EN
   logic               is_div_reg, is_div_next;
`endif

   logic               accept;
   logic               launch_iter;
   logic [XLEN-1:0]    alu_result;
   logic [SHW-1:0]     shamt;
   logic [XLEN-1:0]    a_rev, srl_rev, sll_res;
   logic               a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]    mag_a, mag_b;
   logic               is_mul_op;

   assign in_ready   = (state_reg == ST_IDLE) || (state_reg == ST_DONE && out_ready);
   assign accept     = in_valid && in_ready && !flush;
   assign out_valid  = out_valid_reg;
   assign out_result = out_result_reg;
   assign out_tag    = out_tag_reg;

   // Left shift reuses the right shifter on the bit-reversed operand.
   assign shamt   = in_b[SHW-1:0];
   assign srl_rev = a_rev >> shamt;
   generate
      for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
         assign a_rev[gi]   = in_a[XLEN-1-gi];
         assign sll_res[gi] = srl_rev[XLEN-1-gi];
      end
   endgenerate

   assign is_mul_op = (in_op[4:2] == 3'b100);

`ifdef ALU_MDU_DIV_EN
   logic is_div_op, div_b_zero, div_ovf;
   assign is_div_op   = (in_op[4:2] == 3'b101);
   assign div_b_zero  = (in_b == '0);
   assign div_ovf     = !in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
   assign launch_iter = is_mul_op || (is_div_op && !div_b_zero && !div_ovf);
`else
   assign launch_iter = is_mul_op;
`endif

   always_comb begin
      alu_result = '0;
      case (in_op)
         OP_ADD:  alu_result = in_a + in_b;
         OP_SUB:  alu_result = in_a - in_b;
         OP_AND:  alu_result = in_a & in_b;
         OP_OR:   alu_result = in_a | in_b;
         OP_XOR:  alu_result = in_a ^ in_b;
         OP_SLL:  alu_result = sll_res;
         OP_SRL:  alu_result = in_a >> shamt;
         OP_SRA:  alu_result = $signed(in_a) >>> shamt;
         OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
`ifdef ALU_MDU_DIV_EN
         // Only the special cases reach this path; normal divides go iterative.
         OP_DIV, OP_DIVU: begin
            if (div_b_zero)   alu_result = '1;
            else if (div_ovf) alu_result = in_a;
         end
         OP_REM, OP_REMU: begin
            if (div_b_zero)   alu_result = in_a;
         end
`endif
         default: alu_result = '0;
      endcase
   end

   // Iterative ops run on magnitudes; the sign is re-applied on the final cycle.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (in_op)
         OP_MULH:         begin a_signed = 1'b1; b_signed = 1'b1; end
         OP_MULHSU:       begin a_signed = 1'b1; end
         OP_DIV, OP_REM:  begin a_signed = 1'b1; b_signed = 1'b1; end
         default:         begin a_signed = 1'b0; b_signed = 1'b0; end
      endcase
      a_neg = a_signed && in_a[XLEN-1];
      b_neg = b_signed && in_b[XLEN-1];
      mag_a = a_neg ? (~in_a + 1'b1) : in_a;
      mag_b = b_neg ? (~in_b + 1'b1) : in_b;
   end

   // Multiply step: add multiplicand when the multiplier LSB is set, then shift {hi,lo} right.
   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] mul_hi, mul_lo, mul_final;
   assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
   assign mul_hi    = mul_sum[XLEN:1];
   assign mul_lo    = {mul_sum[0], lo_reg[XLEN-1:1]};
   assign mul_final = !sel_hi_reg ? mul_lo :
                      (neg_reg ? (~mul_hi + XLEN'(mul_lo == '0)) : mul_hi);

   logic [XLEN-1:0] step_hi, step_lo, step_final;
`ifdef ALU_MDU_DIV_EN
   // Restoring divide step: hi holds the partial remainder, lo shifts dividend out and quotient in.
   logic [XLEN:0]   rem_sh, div_diff;
   logic            div_ge;
   logic [XLEN-1:0] div_hi, div_lo, div_pick;
   assign rem_sh   = {hi_reg, lo_reg[XLEN-1]};
   assign div_diff = rem_sh - {1'b0, opnd_reg};
   assign div_ge   = !div_diff[XLEN];
   assign div_hi   = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign div_lo   = {lo_reg[XLEN-2:0], div_ge};
   assign div_pick = sel_hi_reg ? div_hi : div_lo;

   assign step_hi    = is_div_reg ? div_hi : mul_hi;
   assign step_lo    = is_div_reg ? div_lo : mul_lo;
   assign step_final = is_div_reg ? (neg_reg ? (~div_pick + 1'b1) : div_pick) : mul_final;
`else
   assign step_hi    = mul_hi;
   assign step_lo    = mul_lo;
   assign step_final = mul_final;
`endif

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      hi_next         = hi_reg;
      lo_next         = lo_reg;
      opnd_next       = opnd_reg;
      neg_next        = neg_reg;
      sel_hi_next     = sel_hi_reg;
      tag_next        = tag_reg;
      out_valid_next  = out_valid_reg;
      out_result_next = out_result_reg;
      out_tag_next    = out_tag_reg;
`ifdef ALU_MDU_DIV_EN
      is_div_next     = is_div_reg;
`endif

      case (state_reg)
         ST_IDLE: ;
         ST_BUSY: begin
            hi_next  = step_hi;
            lo_next  = step_lo;
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next      = ST_DONE;
               out_valid_next  = 1'b1;
               out_result_next = step_final;
               out_tag_next    = tag_reg;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next     = ST_IDLE;
               out_valid_next = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Accept can only happen in IDLE or in DONE while the result is consumed.
      if (accept) begin
         tag_next = in_tag;
         if (launch_iter) begin
            state_next     = ST_BUSY;
            cnt_next       = CNT_W'(XLEN);
            out_valid_next = 1'b0;
            hi_next        = '0;
            neg_next       = a_neg ^ b_neg;
            sel_hi_next    = (in_op[1:0] != 2'b00);
            lo_next        = mag_b;
            opnd_next      = mag_a;
`ifdef ALU_MDU_DIV_EN
            is_div_next    = in_op[2];
            if (in_op[2]) begin
               lo_next     = mag_a;
               opnd_next   = mag_b;
               sel_hi_next = in_op[1];
               neg_next    = in_op[1] ? a_neg : (a_neg ^ b_neg);
            end
`endif
         end else begin
            state_next      = ST_DONE;
            out_valid_next  = 1'b1;
            out_result_next = alu_result;
            out_tag_next    = in_tag;
         end
      end

      if (flush) begin
         state_next     = ST_IDLE;
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         hi_reg         <= '0;
         lo_reg         <= '0;
         opnd_reg       <= '0;
         neg_reg        <= 1'b0;
         sel_hi_reg     <= 1'b0;
         tag_reg        <= '0;
         out_valid_reg  <= 1'b0;
         out_result_reg <= '0;
         out_tag_reg    <= '0;
`ifdef ALU_MDU_DIV_EN
         is_div_reg     <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         hi_reg         <= hi_next;
         lo_reg         <= lo_next;
         opnd_reg       <= opnd_next;
         neg_reg        <= neg_next;
         sel_hi_reg     <= sel_hi_next;
         tag_reg        <= tag_next;
         out_valid_reg  <= out_valid_next;
         out_result_reg <= out_result_next;
         out_tag_reg    <= out_tag_next;
`ifdef ALU_MDU_DIV_EN
         is_div_reg     <= is_div_next;
`endif
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed vectors queue expected results; a monitor checks
// result, tag, latency and back-pressure stability at every negedge.
module tb_alu_mdu;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam int L1    = 1;
   localparam int LM    = XLEN + 1;

   localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, AND_ = 5'h02, OR_ = 5'h03, XOR_ = 5'h04;
   localparam logic [4:0] SLL = 5'h05, SRL = 5'h06, SRA = 5'h07, SLT = 5'h08, SLTU = 5'h09;
   localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
   localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [4:0]       in_op = '0;
   logic [XLEN-1:0]  in_a = '0;
   logic [XLEN-1:0]  in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;

   alu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
      int               acc;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res, input int lat,
                        input bit push, output int waits);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) chk("issue_in_ready_timeout", in_ready, 1);
      else if (push) sb.push_back('{res, tag, cyc, lat});
      @(posedge clk);
      #1;
   endtask

   int w;
   task automatic send(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res, input int lat);
      int wl;
      issue(op, a, b, tag, res, lat, 1'b1, wl);
      $display("issue op=%02h a=%08h b=%08h tag=%02h exp=%08h lat=%0d", op, a, b, tag, res, lat);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor
   logic             prev_valid = 1'b0, prev_ready = 1'b0, prev_flush = 1'b0;
   logic [XLEN-1:0]  prev_result = '0;
   logic [TAG_W-1:0] prev_tag = '0;
   int               first_cyc = 0;
   exp_t             mon_e;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_flush = 1'b0;
      end else begin
         if (prev_valid && !prev_ready && !prev_flush) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, prev_result);
            chk("hold_tag", out_tag, prev_tag);
         end
         if (out_valid && !(prev_valid && !prev_ready)) begin
            first_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("result", out_result, mon_e.res);
            chk("tag", out_tag, mon_e.tag);
            chk("latency", first_cyc - mon_e.acc, mon_e.lat);
            $display("result tag=%02h got=%08h exp=%08h latency=%0d", out_tag, out_result,
                     mon_e.res, first_cyc - mon_e.acc);
         end
         prev_valid  = out_valid;
         prev_ready  = out_ready;
         prev_flush  = flush;
         prev_result = out_result;
         prev_tag    = out_tag;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_result", out_result, 0);
      chk("reset_out_tag", out_tag, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single-cycle ops, back to back with out_ready high
      send(ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'h01, 32'h8000_0000, L1);
      issue(SUB, 32'h0000_0005, 32'h0000_0007, 5'h02, 32'hFFFF_FFFE, L1, 1'b1, w);
      chk("b2b_accept_wait", w, 0);
      send(AND_, 32'h0000_F0F0, 32'h0000_FF00, 5'h03, 32'h0000_F000, L1);
      send(OR_,  32'h0000_F0F0, 32'h0000_FF00, 5'h04, 32'h0000_FFF0, L1);
      send(XOR_, 32'h0000_F0F0, 32'h0000_FF00, 5'h05, 32'h0000_0FF0, L1);
      send(SLL,  32'h0000_0001, 32'h0000_001F, 5'h06, 32'h8000_0000, L1);
      send(SLL,  32'h0000_0001, 32'h0000_0021, 5'h07, 32'h0000_0002, L1);
      send(SRL,  32'h8000_0000, 32'h0000_001F, 5'h08, 32'h0000_0001, L1);
      send(SRA,  32'h8000_0000, 32'h0000_001F, 5'h09, 32'hFFFF_FFFF, L1);
      send(SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'h0A, 32'h0000_0001, L1);
      send(SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'h0B, 32'h0000_0001, L1);
      send(SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'h0C, 32'h0000_0000, L1);
      send(5'h0A, 32'h1234_5678, 32'h1111_1111, 5'h0D, 32'h0000_0000, L1);
      send(5'h1F, 32'h1234_5678, 32'h1111_1111, 5'h0E, 32'h0000_0000, L1);
      idle(2);

      // Multiplier
      send(MUL,    32'h0000_0006, 32'h0000_0007, 5'h10, 32'h0000_002A, LM);
      send(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h11, 32'h0000_0000, LM);
      send(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFE, LM);
      send(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'h12, 32'hFFFF_FFFF, LM);
      send(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h13, 32'h0000_0001, LM);
      send(MULH,   32'h8000_0000, 32'h8000_0000, 5'h14, 32'h4000_0000, LM);

      // Divider
`ifdef ALU_MDU_DIV_EN
      send(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'h15, 32'hFFFF_FFFD, LM);
      send(REM,  32'hFFFF_FFF9, 32'h0000_0002, 5'h16, 32'hFFFF_FFFF, LM);
      send(DIV,  32'h0000_0007, 32'hFFFF_FFFE, 5'h17, 32'hFFFF_FFFD, LM);
      send(REM,  32'h0000_0007, 32'hFFFF_FFFE, 5'h18, 32'h0000_0001, LM);
      send(DIVU, 32'h0000_0064, 32'h0000_0003, 5'h19, 32'h0000_0021, LM);
      send(REMU, 32'h0000_0064, 32'h0000_0003, 5'h1A, 32'h0000_0001, LM);
      send(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'h1B, 32'h0000_0000, LM);
      send(DIV,  32'h0000_1234, 32'h0000_0000, 5'h1C, 32'hFFFF_FFFF, L1);
      send(DIVU, 32'h0000_1234, 32'h0000_0000, 5'h1D, 32'hFFFF_FFFF, L1);
      send(REM,  32'h0000_1234, 32'h0000_0000, 5'h1E, 32'h0000_1234, L1);
      send(REMU, 32'h8000_0001, 32'h0000_0000, 5'h01, 32'h8000_0001, L1);
      send(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'h02, 32'h8000_0000, L1);
      send(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'h03, 32'h0000_0000, L1);
`else
      send(DIVU, 32'h0000_0064, 32'h0000_0003, 5'h15, 32'h0000_0000, L1);
      send(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'h16, 32'h0000_0000, L1);
      send(REM,  32'h0000_0005, 32'h0000_0000, 5'h17, 32'h0000_0000, L1);
      send(REMU, 32'h0000_0064, 32'h0000_0003, 5'h18, 32'h0000_0000, L1);
`endif
      idle(3);

      // Back-pressure on a multiply result
      out_ready = 1'b0;
      send(MUL, 32'h0000_1234, 32'h0000_0010, 5'h0A, 32'h0001_2340, LM);
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("bp_out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready_low", in_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(ADD, 32'h0000_0003, 32'h0000_0004, 5'h0B, 32'h0000_0007, L1, 1'b1, w);
      chk("bp_release_accept_wait", w, 0);
      idle(3);

      // Flush mid-operation: nothing may come out of the aborted op
`ifdef ALU_MDU_DIV_EN
      issue(DIVU, 32'h0000_03E8, 32'h0000_0007, 5'h05, 32'h0, LM, 1'b0, w);
`else
      issue(MULHU, 32'h0000_03E8, 32'h0000_0007, 5'h05, 32'h0, LM, 1'b0, w);
`endif
      idle(9);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      idle(40);
      send(ADD, 32'h0000_0010, 32'h0000_0020, 5'h06, 32'h0000_0030, L1);
      idle(5);

      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
